brq_fp_issue_ctrl: RTL and testbench

Sequences floating-point instructions from the ID stage into the shared FPU (fpnew) and returns results to writeback. Allows one operation in flight. Resolves dynamic rounding mode against the frm CSR and rejects illegal rounding modes. Handles flush and reports accrued exception flags to the fcsr block.

---
 rtl/brq_pkg.sv | 32 +++
 rtl/brq_fp_watchdog.sv | 30 +++
 rtl/brq_fp_issue_ctrl.sv | 140 ++++++++++++++
 tb/tb_brq_fp_issue_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/brq_pkg.sv
// Shared types for the FP issue path: rounding-mode encodings, issue FSM states,
// and rounding-mode resolution helpers.
package brq_pkg;

  parameter int FP_FFLAGS_W = 5;

  typedef enum logic [2:0] {
    FP_RM_RNE = 3'd0,
    FP_RM_RTZ = 3'd1,
    FP_RM_RDN = 3'd2,
    FP_RM_RUP = 3'd3,
    FP_RM_RMM = 3'd4,
    FP_RM_DYN = 3'd7
  } fp_rm_e;

  typedef enum logic [1:0] {
    FP_IDLE,
    FP_ISSUE,
    FP_WAIT,
    FP_WB
  } fp_issue_state_e;

  // DYN defers to the frm CSR sampled at accept time.
  function automatic logic [2:0] fp_resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
    return (rm == FP_RM_DYN) ? frm : rm;
  endfunction

  function automatic logic fp_rm_legal(input logic [2:0] rm);
    return (rm <= FP_RM_RMM);
  endfunction

endpackage

// File: rtl/brq_fp_watchdog.sv
// WAIT-state watchdog: counts cycles spent waiting on the FPU and flags the
// final allowed cycle. Only instantiated when BRQ_FP_TIMEOUT_EN is defined.
module brq_fp_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CW'(LIMIT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires in the LIMIT-th waiting cycle, when the count is about to reach LIMIT.
  assign o_expire = i_en && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/brq_fp_issue_ctrl.sv
// Single-outstanding FP issue controller between ID, the shared FPU and writeback.
// Optional WAIT watchdog is enabled by defining BRQ_FP_TIMEOUT_EN.
//
// state    | meaning
// FP_IDLE  | ready for a new FP instruction from ID
// FP_ISSUE | operation presented to the FPU, waiting for in_ready
// FP_WAIT  | operation in flight, waiting for the FPU result
// FP_WB    | result held for writeback, fflags strobed on wb handshake
module brq_fp_issue_ctrl
  import brq_pkg::*;
#(
  parameter int RD_W           = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   id_fp_valid_i,
  output logic                   id_fp_ready_o,
  input  logic [2:0]             id_fp_rm_i,
  input  logic                   id_fp_use_rm_i,
  input  logic [RD_W-1:0]        id_fp_rd_i,
  input  logic                   id_fp_dst_int_i,
  input  logic [2:0]             csr_frm_i,
  output logic                   fpu_in_valid_o,
  input  logic                   fpu_in_ready_i,
  output logic [2:0]             fpu_rm_o,
  input  logic                   fpu_out_valid_i,
  output logic                   fpu_out_ready_o,
  input  logic [FP_FFLAGS_W-1:0] fpu_status_i,
  output logic                   fpu_flush_o,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [RD_W-1:0]        wb_rd_o,
  output logic                   wb_int_o,
  output logic                   csr_fflags_we_o,
  output logic [FP_FFLAGS_W-1:0] csr_fflags_set_o,
  output logic                   illegal_rm_o,
  input  logic                   flush_i,
  output logic                   busy_o,
  output logic                   timeout_o
);

  fp_issue_state_e        r_state;
  logic                   r_alive;
  logic [2:0]             r_rm;
  logic [RD_W-1:0]        r_rd;
  logic                   r_int;
  logic [FP_FFLAGS_W-1:0] r_status;
  logic                   r_illegal;

  logic       w_accept;
  logic [2:0] w_rm_res;
  logic       w_rm_bad;
  logic       w_timeout;

  assign w_rm_res = fp_resolve_rm(id_fp_rm_i, csr_frm_i);
  assign w_rm_bad = id_fp_use_rm_i && !fp_rm_legal(w_rm_res);
  assign w_accept = id_fp_valid_i && id_fp_ready_o;

`ifdef BRQ_FP_TIMEOUT_EN
  logic w_expire;

  brq_fp_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_clr   ((r_state == FP_ISSUE) && fpu_in_ready_i),
    .i_en    (r_state == FP_WAIT),
    .o_expire(w_expire)
  );

  // A result landing in the expiry cycle wins; flush outranks both.
  assign w_timeout = w_expire && !fpu_out_valid_i && !flush_i;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= FP_IDLE;
      r_alive   <= 1'b0;
      r_rm      <= '0;
      r_rd      <= '0;
      r_int     <= 1'b0;
      r_status  <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_alive   <= 1'b1;
      r_illegal <= 1'b0;
      unique case (r_state)
        FP_IDLE: begin
          if (w_accept) begin
            if (w_rm_bad) begin
              r_illegal <= 1'b1;
            end else begin
              r_rm    <= w_rm_res;
              r_rd    <= id_fp_rd_i;
              r_int   <= id_fp_dst_int_i;
              r_state <= FP_ISSUE;
            end
          end
        end
        FP_ISSUE: begin
          if (flush_i)             r_state <= FP_IDLE;
          else if (fpu_in_ready_i) r_state <= FP_WAIT;
        end
        FP_WAIT: begin
          if (flush_i || w_timeout) begin
            r_state <= FP_IDLE;
          end else if (fpu_out_valid_i) begin
            r_status <= fpu_status_i;
            r_state  <= FP_WB;
          end
        end
        FP_WB: begin
          if (flush_i || wb_ready_i) r_state <= FP_IDLE;
        end
      endcase
    end
  end

  // r_alive keeps ready low until the first clock after reset release.
  assign id_fp_ready_o    = r_alive && (r_state == FP_IDLE) && !flush_i;
  assign fpu_in_valid_o   = (r_state == FP_ISSUE) && !flush_i;
  assign fpu_rm_o         = (r_state == FP_ISSUE) ? r_rm : 3'd0;
  assign fpu_out_ready_o  = (r_state == FP_WAIT);
  assign fpu_flush_o      = (((r_state == FP_ISSUE) || (r_state == FP_WAIT)) && flush_i) || w_timeout;
  assign wb_valid_o       = (r_state == FP_WB) && !flush_i;
  assign wb_rd_o          = (r_state == FP_WB) ? r_rd : '0;
  assign wb_int_o         = (r_state == FP_WB) && r_int;
  assign csr_fflags_we_o  = (r_state == FP_WB) && wb_ready_i && !flush_i;
  assign csr_fflags_set_o = csr_fflags_we_o ? r_status : '0;
  assign illegal_rm_o     = r_illegal;
  assign busy_o           = (r_state != FP_IDLE);
  assign timeout_o        = w_timeout;

endmodule

// File: tb/tb_brq_fp_issue_ctrl.sv
// Directed bench for brq_fp_issue_ctrl; inputs driven at the falling edge,
// outputs sampled 1ns later. Timeout section follows BRQ_FP_TIMEOUT_EN.
module tb_brq_fp_issue_ctrl;

  localparam int RD_W = 5;

  logic            clk_i;
  logic            rst_ni;
  logic            id_fp_valid_i;
  logic            id_fp_ready_o;
  logic [2:0]      id_fp_rm_i;
  logic            id_fp_use_rm_i;
  logic [RD_W-1:0] id_fp_rd_i;
  logic            id_fp_dst_int_i;
  logic [2:0]      csr_frm_i;
  logic            fpu_in_valid_o;
  logic            fpu_in_ready_i;
  logic [2:0]      fpu_rm_o;
  logic            fpu_out_valid_i;
  logic            fpu_out_ready_o;
  logic [4:0]      fpu_status_i;
  logic            fpu_flush_o;
  logic            wb_valid_o;
  logic            wb_ready_i;
  logic [RD_W-1:0] wb_rd_o;
  logic            wb_int_o;
  logic            csr_fflags_we_o;
  logic [4:0]      csr_fflags_set_o;
  logic            illegal_rm_o;
  logic            flush_i;
  logic            busy_o;
  logic            timeout_o;

  brq_fp_issue_ctrl #(
    .RD_W          (RD_W),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .id_fp_valid_i   (id_fp_valid_i),
    .id_fp_ready_o   (id_fp_ready_o),
    .id_fp_rm_i      (id_fp_rm_i),
    .id_fp_use_rm_i  (id_fp_use_rm_i),
    .id_fp_rd_i      (id_fp_rd_i),
    .id_fp_dst_int_i (id_fp_dst_int_i),
    .csr_frm_i       (csr_frm_i),
    .fpu_in_valid_o  (fpu_in_valid_o),
    .fpu_in_ready_i  (fpu_in_ready_i),
    .fpu_rm_o        (fpu_rm_o),
    .fpu_out_valid_i (fpu_out_valid_i),
    .fpu_out_ready_o (fpu_out_ready_o),
    .fpu_status_i    (fpu_status_i),
    .fpu_flush_o     (fpu_flush_o),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wb_ready_i),
    .wb_rd_o         (wb_rd_o),
    .wb_int_o        (wb_int_o),
    .csr_fflags_we_o (csr_fflags_we_o),
    .csr_fflags_set_o(csr_fflags_set_o),
    .illegal_rm_o    (illegal_rm_o),
    .flush_i         (flush_i),
    .busy_o          (busy_o),
    .timeout_o       (timeout_o)
  );

  logic [21:0] w_all_out;
  assign w_all_out = {id_fp_ready_o, fpu_in_valid_o, fpu_rm_o, fpu_out_ready_o, fpu_flush_o,
                      wb_valid_o, wb_rd_o, wb_int_o, csr_fflags_we_o, csr_fflags_set_o,
                      illegal_rm_o, busy_o, timeout_o};

  int n_chk = 0;
  int n_fail = 0;
  int n_we = 0, n_fl = 0, n_ill = 0, n_inv = 0, n_wbv = 0;
  int b_we, b_fl, b_ill, b_inv, b_wbv;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (csr_fflags_we_o) n_we  <= n_we + 1;
    if (fpu_flush_o)     n_fl  <= n_fl + 1;
    if (illegal_rm_o)    n_ill <= n_ill + 1;
    if (fpu_in_valid_o)  n_inv <= n_inv + 1;
    if (wb_valid_o)      n_wbv <= n_wbv + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL tb_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst_ni = 1'b0;
    id_fp_valid_i = 0; id_fp_rm_i = 0; id_fp_use_rm_i = 0; id_fp_rd_i = 0; id_fp_dst_int_i = 0;
    csr_frm_i = 0; fpu_in_ready_i = 0; fpu_out_valid_i = 0; fpu_status_i = 0;
    wb_ready_i = 0; flush_i = 0;

    // reset
    nx(); #1 chk("rst_outs", 32'(w_all_out), 0);
    nx(); rst_ni = 1'b1; #1 chk("rst_rel_outs", 32'(w_all_out), 0);
    nx(); #1 chk("idle_ready", id_fp_ready_o, 1);
    chk("idle_busy", busy_o, 0);

    // static rm, FPU result in third WAIT cycle
    b_we = n_we;
    id_fp_valid_i = 1; id_fp_rm_i = 3'b001; id_fp_use_rm_i = 1; id_fp_rd_i = 5'd9;
    id_fp_dst_int_i = 0; fpu_in_ready_i = 1; wb_ready_i = 1; fpu_status_i = 5'b00001;
    csr_frm_i = 3'b100;
    nx(); id_fp_valid_i = 0; #1 chk("s_in_valid", fpu_in_valid_o, 1);
    chk("s_rm", fpu_rm_o, 3'b001);
    nx(); fpu_in_ready_i = 0; #1 chk("s_out_ready", fpu_out_ready_o, 1);
    nx();
    nx(); fpu_out_valid_i = 1; #1 chk("s_wb_early", wb_valid_o, 0);
    nx(); fpu_out_valid_i = 0; #1 chk("s_wb_valid", wb_valid_o, 1);
    chk("s_wb_rd", wb_rd_o, 5'd9);
    chk("s_we", csr_fflags_we_o, 1);
    chk("s_set", csr_fflags_set_o, 5'b00001);
    nx(); #1 chk("s_idle", busy_o, 0);
    chk("s_we_cnt", n_we - b_we, 1);

    // dynamic rm, frm changes after accept
    id_fp_valid_i = 1; id_fp_rm_i = 3'b111; csr_frm_i = 3'b011; id_fp_use_rm_i = 1;
    id_fp_rd_i = 5'd3; fpu_in_ready_i = 0; fpu_status_i = 5'b00000;
    nx(); id_fp_valid_i = 0; csr_frm_i = 3'b000; #1 chk("d_rm_issue", fpu_rm_o, 3'b011);
    nx(); fpu_in_ready_i = 1; #1 chk("d_rm_hold", fpu_rm_o, 3'b011);
    chk("d_in_valid", fpu_in_valid_o, 1);
    nx(); fpu_in_ready_i = 0; fpu_out_valid_i = 1;
    nx(); fpu_out_valid_i = 0; #1 chk("d_wb_valid", wb_valid_o, 1);
    chk("d_zero_we", csr_fflags_we_o, 1);
    chk("d_zero_set", csr_fflags_set_o, 5'b00000);
    nx();

    // illegal rm via frm=5, then same with use_rm=0
    b_ill = n_ill; b_inv = n_inv;
    id_fp_valid_i = 1; id_fp_rm_i = 3'b111; csr_frm_i = 3'b101; id_fp_use_rm_i = 1;
    nx(); id_fp_valid_i = 0; #1 chk("i_pulse", illegal_rm_o, 1);
    chk("i_busy", busy_o, 0);
    chk("i_in_valid", fpu_in_valid_o, 0);
    nx(); #1 chk("i_pulse_end", illegal_rm_o, 0);
    nx(); #1 chk("i_cnt", n_ill - b_ill, 1);
    chk("i_no_issue", n_inv - b_inv, 0);
    id_fp_valid_i = 1; id_fp_use_rm_i = 0; fpu_in_ready_i = 1; fpu_status_i = 5'b10000;
    nx(); id_fp_valid_i = 0; #1 chk("i_nouse_issue", fpu_in_valid_o, 1);
    chk("i_nouse_rm", fpu_rm_o, 3'b101);
    chk("i_nouse_ill", illegal_rm_o, 0);
    nx(); fpu_in_ready_i = 0; fpu_out_valid_i = 1;
    nx(); fpu_out_valid_i = 0; #1 chk("i_nouse_set", csr_fflags_set_o, 5'b10000);
    nx();

    // backpressure on FPU input and writeback
    b_we = n_we;
    id_fp_valid_i = 1; id_fp_rm_i = 3'b010; id_fp_use_rm_i = 1; id_fp_rd_i = 5'd17;
    id_fp_dst_int_i = 1; fpu_in_ready_i = 0; wb_ready_i = 0; csr_frm_i = 3'b000;
    fpu_status_i = 5'b00110;
    nx(); id_fp_valid_i = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp_in_valid", fpu_in_valid_o, 1);
      chk("bp_rm", fpu_rm_o, 3'b010);
      nx();
    end
    fpu_in_ready_i = 1; #1 chk("bp_in_valid_hs", fpu_in_valid_o, 1);
    nx(); fpu_in_ready_i = 0; fpu_out_valid_i = 1;
    nx(); fpu_out_valid_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_wb_valid", wb_valid_o, 1);
      chk("bp_wb_rd", wb_rd_o, 5'd17);
      chk("bp_wb_int", wb_int_o, 1);
      chk("bp_no_we", csr_fflags_we_o, 0);
      nx();
    end
    wb_ready_i = 1; #1 chk("bp_we", csr_fflags_we_o, 1);
    chk("bp_set", csr_fflags_set_o, 5'b00110);
    nx(); wb_ready_i = 0; #1 chk("bp_idle", busy_o, 0);
    chk("bp_we_cnt", n_we - b_we, 1);

    // flush in WAIT coincident with a result
    b_we = n_we; b_fl = n_fl; b_wbv = n_wbv;
    id_fp_valid_i = 1; id_fp_rm_i = 3'b000; id_fp_rd_i = 5'd1; id_fp_dst_int_i = 0;
    fpu_in_ready_i = 1; wb_ready_i = 1; fpu_status_i = 5'b11111;
    nx(); id_fp_valid_i = 0;
    nx(); fpu_in_ready_i = 0; flush_i = 1; fpu_out_valid_i = 1;
    #1 chk("fw_flush", fpu_flush_o, 1);
    chk("fw_ready", id_fp_ready_o, 0);
    nx(); flush_i = 0; fpu_out_valid_i = 0; #1 chk("fw_flush_end", fpu_flush_o, 0);
    chk("fw_idle", busy_o, 0);
    chk("fw_no_wb", wb_valid_o, 0);
    chk("fw_ready_back", id_fp_ready_o, 1);
    nx(); #1 chk("fw_we_cnt", n_we - b_we, 0);
    chk("fw_fl_cnt", n_fl - b_fl, 1);
    chk("fw_wbv_cnt", n_wbv - b_wbv, 0);

    // flush in IDLE blocks accept
    id_fp_valid_i = 1; flush_i = 1; #1 chk("fi_ready", id_fp_ready_o, 0);
    nx(); id_fp_valid_i = 0; flush_i = 0; #1 chk("fi_busy", busy_o, 0);

    // flush in WB drops result
    id_fp_valid_i = 1; fpu_in_ready_i = 1; wb_ready_i = 0;
    nx(); id_fp_valid_i = 0;
    nx(); fpu_in_ready_i = 0; fpu_out_valid_i = 1;
    nx(); fpu_out_valid_i = 0; #1 chk("fb_wb_valid", wb_valid_o, 1);
    wb_ready_i = 1; flush_i = 1; #1 chk("fb_no_we", csr_fflags_we_o, 0);
    chk("fb_wb_drop", wb_valid_o, 0);
    nx(); flush_i = 0; wb_ready_i = 0; #1 chk("fb_idle", busy_o, 0);

    // FPU never responds
    id_fp_valid_i = 1; fpu_in_ready_i = 1;
    nx(); id_fp_valid_i = 0;
    nx(); fpu_in_ready_i = 0;
`ifdef BRQ_FP_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (k < 8) begin
        chk("to_quiet", timeout_o, 0);
        chk("to_busy", busy_o, 1);
      end else begin
        chk("to_pulse", timeout_o, 1);
        chk("to_flush", fpu_flush_o, 1);
      end
      nx();
    end
    #1 chk("to_idle", busy_o, 0);
    chk("to_end", timeout_o, 0);
`else
    for (int k = 0; k < 20; k++) begin
      #1 chk("nto_quiet", timeout_o, 0);
      chk("nto_busy", busy_o, 1);
      nx();
    end
    flush_i = 1;
    nx(); flush_i = 0; #1 chk("nto_idle", busy_o, 0);
`endif

    // asynchronous reset mid-ISSUE
    nx();
    id_fp_valid_i = 1; id_fp_rm_i = 3'b001; fpu_in_ready_i = 0;
    nx(); id_fp_valid_i = 0; #1 chk("ar_issue", fpu_in_valid_o, 1);
    #2 rst_ni = 1'b0;
    #1 chk("ar_outs", 32'(w_all_out), 0);
    nx(); rst_ni = 1'b1;
    nx(); #1 chk("ar_ready", id_fp_ready_o, 1);
    chk("ar_busy", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
